cnt_prog: RTL and testbench

- Runtime-programmable modulo counter for the uart_var datapath: baud dividers, bit/oversample counters, frame timers.
- Generalises the fixed-modulus up/down counter:
  - width parameter;
  - modulus, direction, enable, clear and parallel load at run time;
  - terminal-count pulse;
  - optional one-shot (stop-at-terminal) mode with a done flag.
- Instanced once per divider/timer; tc feeds the next counter's en for cascading.

---
 rtl/cnt_pkg.sv | 16 +
 rtl/cnt_prog.sv | 85 ++++++++
 tb/tb_cnt_prog.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// Shared constants for the programmable modulo counter family.
package cnt_pkg;

    localparam logic CNT_UP    = 1'b0;
    localparam logic CNT_DOWN  = 1'b1;
    localparam int   CNT_MAX_W = 64;

    // Last count value M-1 reduced to w bits, so that M=0 yields all-ones.
    function automatic logic [CNT_MAX_W-1:0] last_of(input logic [CNT_MAX_W-1:0] m,
                                                    input int unsigned w);
        logic [CNT_MAX_W-1:0] mask;
        mask = (w >= CNT_MAX_W) ? {CNT_MAX_W{1'b1}} : ((64'd1 << w) - 64'd1);
        return (m - 64'd1) & mask;
    endfunction

endpackage

// File: rtl/cnt_prog.sv
// Runtime-programmable up/down modulo counter with terminal-count pulse
// and optional one-shot stop-at-terminal behaviour.
import cnt_pkg::*;

module cnt_prog #(
    parameter int WIDTH   = 16,
    parameter int ONESHOT = 0,
    parameter int TC_REG  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] cnt_value,
    output logic             tc,
    output logic             done
);

    logic [WIDTH-1:0] m_last;
    logic [WIDTH-1:0] cnt_p0;
    logic [WIDTH-1:0] cnt_next;
    logic             terminal;
    logic             step;
    logic             tc_p0;
    logic             tc_p1;
    logic             done_q;

    assign m_last = WIDTH'(last_of(CNT_MAX_W'(mod_val), WIDTH));

    always_comb begin
        terminal = (dir == CNT_UP) ? (cnt_p0 >= m_last)
                                   : ((cnt_p0 == '0) || (cnt_p0 > m_last));
        step     = en && !clr && !load && !done_q;
        tc_p0    = step && terminal;
        cnt_next = cnt_p0;
        if (clr) begin
            cnt_next = (dir == CNT_DOWN) ? m_last : '0;
        end else if (load) begin
            // M=0 spans the full range, so a load can never be out of range.
            cnt_next = ((mod_val == '0) || (load_val < mod_val)) ? load_val : m_last;
        end else if (step) begin
            if (terminal) begin
                if (ONESHOT == 0) begin
                    cnt_next = (dir == CNT_UP) ? '0 : m_last;
                end
            end else begin
                cnt_next = (dir == CNT_UP) ? cnt_p0 + WIDTH'(1) : cnt_p0 - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_next;
        end
    end

    // Registered tc and one-shot done flag; both cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_p1  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tc_p1 <= tc_p0;
            if (ONESHOT != 0) begin
                if (clr || load) begin
                    done_q <= 1'b0;
                end else if (tc_p0) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign cnt_value = cnt_p0;
    assign tc        = (TC_REG != 0) ? tc_p1 : tc_p0;
    assign done      = done_q;

endmodule

// File: tb/tb_cnt_prog.sv
// Bench for cnt_prog: free-running, registered-tc and one-shot instances share stimulus.
module tb_cnt_prog;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, clr, dir, load;
    logic [W-1:0] load_val, mod_val;
    logic [W-1:0] cnt_a, cnt_r, cnt_o;
    logic         tc_a, tc_r, tc_o;
    logic         done_a, done_r, done_o;

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    cnt_prog #(.WIDTH(W), .ONESHOT(0), .TC_REG(0)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .dir(dir), .load(load),
        .load_val(load_val), .mod_val(mod_val),
        .cnt_value(cnt_a), .tc(tc_a), .done(done_a));

    cnt_prog #(.WIDTH(W), .ONESHOT(0), .TC_REG(1)) dut_r (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .dir(dir), .load(load),
        .load_val(load_val), .mod_val(mod_val),
        .cnt_value(cnt_r), .tc(tc_r), .done(done_r));

    cnt_prog #(.WIDTH(W), .ONESHOT(1), .TC_REG(0)) dut_o (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .dir(dir), .load(load),
        .load_val(load_val), .mod_val(mod_val),
        .cnt_value(cnt_o), .tc(tc_o), .done(done_o));

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; clr = 1'b0; dir = 1'b0; load = 1'b0;
        load_val = '0; mod_val = 4'd10;
        repeat (2) @(negedge clk);
        total++;
        if ({cnt_a, cnt_r, cnt_o} !== 12'h000) $display("FAIL reset_cnt got %h want 000", {cnt_a, cnt_r, cnt_o});
        else passed++;
        total++;
        if ({tc_a, tc_r, tc_o, done_a, done_r, done_o} !== 6'b0)
            $display("FAIL reset_flags got %b want 000000", {tc_a, tc_r, tc_o, done_a, done_r, done_o});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_up_wrap();
        logic [15:0] e;
        int pa = 0;
        int pr = 0;
        en = 1'b1; dir = 1'b0; mod_val = 4'd10;
        for (int i = 0; i < 25; i++) begin
            #1;
            if (tc_a) pa++;
            if (tc_r) pr++;
            total++;
            if (tc_a !== ((i % 10) == 9)) $display("FAIL up_tc cyc %0d got %b want %b", i, tc_a, (i % 10) == 9);
            else passed++;
            total++;
            if (tc_r !== (i > 0 && (i % 10) == 0)) $display("FAIL up_tcreg cyc %0d got %b want %b", i, tc_r, (i > 0 && (i % 10) == 0));
            else passed++;
            exp_q.push_back(16'((i + 1) % 10));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({12'h0, cnt_a} !== e || {12'h0, cnt_r} !== e)
                $display("FAIL up_cnt cyc %0d got %0d/%0d want %0d", i, cnt_a, cnt_r, e);
            else passed++;
        end
        en = 1'b0;
        total++;
        if (pa != 2 || pr != 2) $display("FAIL up_pulses got %0d/%0d want 2/2", pa, pr);
        else passed++;
    endtask

    task automatic test_down();
        logic [15:0] e;
        dir = 1'b1; mod_val = 4'd5; clr = 1'b1; en = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (cnt_a !== 4'd4) $display("FAIL down_clr got %0d want 4", cnt_a);
        else passed++;
        en = 1'b1;
        for (int j = 0; j < 12; j++) begin
            #1;
            total++;
            if (tc_a !== ((j % 5) == 4)) $display("FAIL down_tc cyc %0d got %b want %b", j, tc_a, (j % 5) == 4);
            else passed++;
            exp_q.push_back(16'(4 - ((j + 1) % 5)));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({12'h0, cnt_a} !== e) $display("FAIL down_cnt cyc %0d got %0d want %0d", j, cnt_a, e);
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [15:0] e;
        int po = 0;
        dir = 1'b0; mod_val = 4'd6; clr = 1'b1; en = 1'b0;
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #1;
            if (tc_o) po++;
            total++;
            if (tc_o !== (j == 5)) $display("FAIL os_tc cyc %0d got %b want %b", j, tc_o, j == 5);
            else passed++;
            exp_q.push_back({11'h0, (j >= 5), 4'((j + 1 > 5) ? 5 : j + 1)});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({11'h0, done_o, cnt_o} !== e) $display("FAIL os_cnt cyc %0d got done=%b cnt=%0d want %h", j, done_o, cnt_o, e);
            else passed++;
        end
        total++;
        if (po != 1) $display("FAIL os_pulses got %0d want 1", po);
        else passed++;
        load = 1'b1; load_val = 4'd2;
        @(negedge clk);
        load = 1'b0;
        total++;
        if (cnt_o !== 4'd2 || done_o !== 1'b0) $display("FAIL os_load got cnt=%0d done=%b want 2/0", cnt_o, done_o);
        else passed++;
        @(negedge clk);
        en = 1'b0;
        total++;
        if (cnt_o !== 4'd3) $display("FAIL os_restart got %0d want 3", cnt_o);
        else passed++;
    endtask

    task automatic test_load_clamp();
        dir = 1'b0; mod_val = 4'd10; load = 1'b1; load_val = 4'd12; en = 1'b0;
        @(negedge clk);
        total++;
        if (cnt_a !== 4'd9) $display("FAIL clamp got %0d want 9", cnt_a);
        else passed++;
        clr = 1'b1; en = 1'b1;
        #1;
        total++;
        if (tc_a !== 1'b0) $display("FAIL clr_load_tc got %b want 0", tc_a);
        else passed++;
        @(negedge clk);
        clr = 1'b0; en = 1'b0;
        total++;
        if (cnt_a !== 4'd0) $display("FAIL clr_wins got %0d want 0", cnt_a);
        else passed++;
        mod_val = 4'd0; load_val = 4'd15;
        @(negedge clk);
        load = 1'b0;
        total++;
        if (cnt_a !== 4'd15) $display("FAIL load_m0 got %0d want 15", cnt_a);
        else passed++;
    endtask

    task automatic test_mod_change();
        logic [15:0] e;
        dir = 1'b0; mod_val = 4'd10; load = 1'b1; load_val = 4'd7; en = 1'b0;
        @(negedge clk);
        load = 1'b0;
        mod_val = 4'd4; en = 1'b1;
        #1;
        total++;
        if (tc_a !== 1'b1) $display("FAIL modchg_tc got %b want 1", tc_a);
        else passed++;
        @(negedge clk);
        en = 1'b0;
        total++;
        if (cnt_a !== 4'd0) $display("FAIL modchg_cnt got %0d want 0", cnt_a);
        else passed++;
        mod_val = 4'd0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        for (int j = 0; j < 17; j++) begin
            #1;
            total++;
            if (tc_a !== (j == 15)) $display("FAIL m0_tc cyc %0d got %b want %b", j, tc_a, j == 15);
            else passed++;
            exp_q.push_back(16'((j + 1) % 16));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if ({12'h0, cnt_a} !== e) $display("FAIL m0_cnt cyc %0d got %0d want %0d", j, cnt_a, e);
            else passed++;
        end
        en = 1'b0;
    endtask

    task automatic test_m1();
        dir = 1'b0; mod_val = 4'd1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            total++;
            if (tc_a !== 1'b1 || cnt_a !== 4'd0) $display("FAIL m1_a cyc %0d got tc=%b cnt=%0d want 1/0", j, tc_a, cnt_a);
            else passed++;
            total++;
            if (tc_o !== (j == 0)) $display("FAIL m1_os cyc %0d got %b want %b", j, tc_o, j == 0);
            else passed++;
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        dir = 1'b0; mod_val = 4'd7; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; en = 1'b1;
        repeat (7) @(negedge clk);
        total++;
        if (cnt_o !== 4'd6 || done_o !== 1'b1 || tc_r !== 1'b1)
            $display("FAIL pre_reset got cnt_o=%0d done_o=%b tc_r=%b want 6/1/1", cnt_o, done_o, tc_r);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (cnt_o !== 4'd0 || done_o !== 1'b0 || cnt_r !== 4'd0 || cnt_a !== 4'd0)
            $display("FAIL async_reset got cnt=%0d/%0d/%0d done=%b want 0", cnt_a, cnt_r, cnt_o, done_o);
        else passed++;
        total++;
        if (tc_r !== 1'b0 || tc_o !== 1'b0 || tc_a !== 1'b0)
            $display("FAIL reset_tc got %b%b%b want 000", tc_a, tc_r, tc_o);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (cnt_a !== 4'd0 || tc_r !== 1'b0) $display("FAIL reset_hold got cnt=%0d tc_r=%b want 0/0", cnt_a, tc_r);
        else passed++;
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_oneshot();
        test_load_clamp();
        test_mod_change();
        test_m1();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got %0d checks want completion", total);
        $fatal(1);
    end

endmodule
